// File: rtl/toy_imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: requester ids and the
// per-request tag carried through the outstanding-request FIFO.
package toy_imem_arbiter_pkg;

  typedef enum logic {
    IMEM_ID_FETCH = 1'b0,
    IMEM_ID_DBG   = 1'b1
  } imem_req_id_e;

  typedef struct packed {
    imem_req_id_e id;
    logic         drop;
  } imem_tag_t;

endpackage

// File: rtl/toy_imem_tag_fifo.sv
// In-order FIFO of outstanding request tags; a flush marks every fetch-owned
// entry as drop so its response is discarded when it reaches the head.
module toy_imem_tag_fifo
  import toy_imem_arbiter_pkg::*;
#(
  parameter int OST_DEPTH = 4,
  localparam int PTR_W = $clog2(OST_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  imem_tag_t        push_tag,
  input  logic             pop,
  input  logic             flush_fetch,
  output imem_tag_t        head_tag,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  imem_tag_t        tag_q [OST_DEPTH];
  imem_tag_t        tag_d [OST_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Marking free slots is harmless: a push always rewrites the whole tag.
    if (flush_fetch) begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        if (tag_q[i].id == IMEM_ID_FETCH) tag_d[i].drop = 1'b1;
      end
    end
    if (push) begin
      tag_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OST_DEPTH; i++) tag_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_tag = tag_q[rd_ptr_q];
  assign full     = (cnt_q == CNT_W'(OST_DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;

endmodule

// File: rtl/toy_imem_arbiter.sv
// Round-robin sharing of one instruction-memory port between fetch and the
// debug loader, with in-order response routing and flush-based discard.
module toy_imem_arbiter
  import toy_imem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OST_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_vld,
  output logic                  fetch_req_rdy,
  input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
  output logic                  fetch_ack_vld,
  input  logic                  fetch_ack_rdy,
  output logic [DATA_WIDTH-1:0] fetch_ack_data,
  input  logic                  fetch_flush,
  input  logic                  dbg_req_vld,
  output logic                  dbg_req_rdy,
  input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
  output logic                  dbg_ack_vld,
  input  logic                  dbg_ack_rdy,
  output logic [DATA_WIDTH-1:0] dbg_ack_data,
  output logic                  mem_req_vld,
  input  logic                  mem_req_rdy,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_ack_vld,
  output logic                  mem_ack_rdy,
  input  logic [DATA_WIDTH-1:0] mem_ack_data
);

  localparam int CNT_W = $clog2(OST_DEPTH) + 1;

  imem_req_id_e     rr_last_q, rr_last_d;
  imem_tag_t        head_tag, push_tag;
  logic             tag_full, tag_empty, tag_pop, req_fire;
  logic             grant_f, grant_d, can_issue, head_is_dbg, head_discard;
  logic [CNT_W-1:0] ost_cnt;

  // Handshake rule on every channel: a transfer happens in a cycle where
  // vld and rdy are both 1; vld never waits on rdy being high first.
  always_comb begin
    grant_f = fetch_req_vld & (~dbg_req_vld | (rr_last_q == IMEM_ID_DBG));
    grant_d = dbg_req_vld & ~grant_f;

    head_is_dbg   = (head_tag.id == IMEM_ID_DBG);
    head_discard  = ~head_is_dbg & (head_tag.drop | fetch_flush);
    fetch_ack_vld = 1'b0;
    dbg_ack_vld   = 1'b0;
    mem_ack_rdy   = 1'b0;
    if (!rst) begin
      if (tag_empty) begin
        mem_ack_rdy = 1'b1;
      end else if (head_is_dbg) begin
        dbg_ack_vld = mem_ack_vld;
        mem_ack_rdy = dbg_ack_rdy;
      end else if (head_discard) begin
        mem_ack_rdy = 1'b1;
      end else begin
        fetch_ack_vld = mem_ack_vld;
        mem_ack_rdy   = fetch_ack_rdy;
      end
    end
    tag_pop = mem_ack_vld & mem_ack_rdy & ~tag_empty;

    // A full FIFO can still accept when its head retires this same cycle.
    can_issue     = ~rst & (~tag_full | tag_pop);
    mem_req_vld   = can_issue & (grant_f | grant_d);
    mem_req_addr  = grant_f ? fetch_req_addr : dbg_req_addr;
    fetch_req_rdy = can_issue & grant_f & mem_req_rdy;
    dbg_req_rdy   = can_issue & grant_d & mem_req_rdy;
    req_fire      = mem_req_vld & mem_req_rdy;

    push_tag.id   = grant_f ? IMEM_ID_FETCH : IMEM_ID_DBG;
    push_tag.drop = 1'b0;
    rr_last_d     = req_fire ? push_tag.id : rr_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= IMEM_ID_DBG;
    else     rr_last_q <= rr_last_d;
  end

  toy_imem_tag_fifo #(
    .OST_DEPTH (OST_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (req_fire),
    .push_tag    (push_tag),
    .pop         (tag_pop),
    .flush_fetch (fetch_flush),
    .head_tag    (head_tag),
    .full        (tag_full),
    .empty       (tag_empty),
    .count       (ost_cnt)
  );

  assign fetch_ack_data = mem_ack_data;
  assign dbg_ack_data   = mem_ack_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_ack_vld && tag_empty));
      assert (ost_cnt <= CNT_W'(OST_DEPTH));
    end
  end

endmodule

// File: tb/tb_toy_imem_arbiter.sv
// Directed bench for toy_imem_arbiter with a response memory model and
// per-requester expected-data queues.
module tb_toy_imem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req_vld, fetch_req_rdy;
  logic [AW-1:0] fetch_req_addr;
  logic          fetch_ack_vld, fetch_ack_rdy;
  logic [DW-1:0] fetch_ack_data;
  logic          fetch_flush;
  logic          dbg_req_vld, dbg_req_rdy;
  logic [AW-1:0] dbg_req_addr;
  logic          dbg_ack_vld, dbg_ack_rdy;
  logic [DW-1:0] dbg_ack_data;
  logic          mem_req_vld, mem_req_rdy;
  logic [AW-1:0] mem_req_addr;
  logic          mem_ack_vld = 1'b0;
  logic          mem_ack_rdy;
  logic [DW-1:0] mem_ack_data = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  toy_imem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .OST_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req_vld  (fetch_req_vld),
    .fetch_req_rdy  (fetch_req_rdy),
    .fetch_req_addr (fetch_req_addr),
    .fetch_ack_vld  (fetch_ack_vld),
    .fetch_ack_rdy  (fetch_ack_rdy),
    .fetch_ack_data (fetch_ack_data),
    .fetch_flush    (fetch_flush),
    .dbg_req_vld    (dbg_req_vld),
    .dbg_req_rdy    (dbg_req_rdy),
    .dbg_req_addr   (dbg_req_addr),
    .dbg_ack_vld    (dbg_ack_vld),
    .dbg_ack_rdy    (dbg_ack_rdy),
    .dbg_ack_data   (dbg_ack_data),
    .mem_req_vld    (mem_req_vld),
    .mem_req_rdy    (mem_req_rdy),
    .mem_req_addr   (mem_req_addr),
    .mem_ack_vld    (mem_ack_vld),
    .mem_ack_rdy    (mem_ack_rdy),
    .mem_ack_data   (mem_ack_data)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  int            fetch_ack_cnt = 0;
  int            dbg_ack_cnt = 0;
  logic          mem_ack_en = 1'b0;
  logic [DW-1:0] exp_fetch_q[$];
  logic [DW-1:0] exp_dbg_q[$];
  logic [DW-1:0] mem_resp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_func(input logic [AW-1:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0013;
      32'h8000_0004: return 32'h0010_0073;
      32'h8000_0100: return 32'hdead_beef;
      default:       return a ^ 32'hc3c3_0f0f;
    endcase
  endfunction

  // Memory model: answers accepted requests in order, one cycle later at best.
  always @(posedge clk) begin
    #2;
    if (mem_ack_en && mem_resp_q.size() > 0) begin
      mem_ack_vld  = 1'b1;
      mem_ack_data = mem_resp_q[0];
    end else begin
      mem_ack_vld  = 1'b0;
      mem_ack_data = '0;
    end
  end

  // Monitor: sampled on the falling edge, inputs only move just after rising.
  always @(negedge clk) begin
    if (rst) begin
      mem_resp_q.delete();
      exp_fetch_q.delete();
      exp_dbg_q.delete();
    end else begin
      if (fetch_ack_vld && fetch_ack_rdy) begin
        fetch_ack_cnt++;
        if (exp_fetch_q.size() == 0) check("fetch_ack_unexpected", 1, 0);
        else check("fetch_ack_data", fetch_ack_data, exp_fetch_q.pop_front());
      end
      if (dbg_ack_vld && dbg_ack_rdy) begin
        dbg_ack_cnt++;
        if (exp_dbg_q.size() == 0) check("dbg_ack_unexpected", 1, 0);
        else check("dbg_ack_data", dbg_ack_data, exp_dbg_q.pop_front());
      end
      if (mem_ack_vld && mem_ack_rdy && mem_resp_q.size() > 0) void'(mem_resp_q.pop_front());
      if (fetch_flush) exp_fetch_q.delete();
      if (mem_req_vld && mem_req_rdy) begin
        check("one_req_rdy", fetch_req_rdy ^ dbg_req_rdy, 1);
        check("mem_req_addr", mem_req_addr, fetch_req_rdy ? fetch_req_addr : dbg_req_addr);
        mem_resp_q.push_back(mem_func(mem_req_addr));
        if (fetch_req_rdy) exp_fetch_q.push_back(mem_func(fetch_req_addr));
        else               exp_dbg_q.push_back(mem_func(dbg_req_addr));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req_vld"}, mem_req_vld, 0);
    check({tag, "_fetch_req_rdy"}, fetch_req_rdy, 0);
    check({tag, "_dbg_req_rdy"}, dbg_req_rdy, 0);
    check({tag, "_fetch_ack_vld"}, fetch_ack_vld, 0);
    check({tag, "_dbg_ack_vld"}, dbg_ack_vld, 0);
    check({tag, "_mem_ack_rdy"}, mem_ack_rdy, 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    mem_ack_en = 1'b1;
    while ((mem_resp_q.size() != 0 || exp_fetch_q.size() != 0 || exp_dbg_q.size() != 0) && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, (n >= 64), 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] fa, da;
    rst = 1'b1;
    fetch_req_vld = 1'b1; fetch_req_addr = 32'h1000_0000;
    dbg_req_vld = 1'b1;   dbg_req_addr = 32'h2000_0000;
    fetch_ack_rdy = 1'b1; dbg_ack_rdy = 1'b1;
    fetch_flush = 1'b0;   mem_req_rdy = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("rst0");
    tick();
    rst = 1'b0;

    // Round-robin from reset: fetch first, saturate at four outstanding.
    fa = 32'h1000_0000; da = 32'h2000_0000;
    for (int i = 0; i < 4; i++) begin
      fetch_req_addr = fa; dbg_req_addr = da;
      @(negedge clk);
      check("t2_grant_f", fetch_req_rdy, (i % 2) == 0);
      check("t2_grant_d", dbg_req_rdy, (i % 2) == 1);
      tick();
      if (i % 2 == 0) fa += 4; else da += 4;
    end
    for (int i = 0; i < 2; i++) begin
      fetch_req_addr = fa; dbg_req_addr = da;
      @(negedge clk);
      check("t2_full_f", fetch_req_rdy, 0);
      check("t2_full_d", dbg_req_rdy, 0);
      check("t2_full_req_vld", mem_req_vld, 0);
      tick();
    end
    mem_ack_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fetch_req_addr = fa; dbg_req_addr = da;
      @(negedge clk);
      check("t2_pop_grant_f", fetch_req_rdy, (i % 2) == 0);
      check("t2_pop_grant_d", dbg_req_rdy, (i % 2) == 1);
      tick();
      if (i % 2 == 0) fa += 4; else da += 4;
    end
    fetch_req_vld = 1'b0; dbg_req_vld = 1'b0;
    drain("t2");

    // Fetch only, responses one cycle after each request.
    fetch_ack_cnt = 0; dbg_ack_cnt = 0;
    fetch_req_vld = 1'b1; fetch_req_addr = 32'h8000_0000;
    @(negedge clk);
    check("t1_req_vld", mem_req_vld, 1);
    check("t1_req_addr0", mem_req_addr, 32'h8000_0000);
    tick();
    fetch_req_addr = 32'h8000_0004;
    @(negedge clk);
    check("t1_req_addr1", mem_req_addr, 32'h8000_0004);
    check("t1_ack_vld", fetch_ack_vld, 1);
    check("t1_ack_data0", fetch_ack_data, 32'h0000_0013);
    tick();
    fetch_req_vld = 1'b0;
    drain("t1");
    check("t1_fetch_acks", fetch_ack_cnt, 2);
    check("t1_dbg_acks", dbg_ack_cnt, 0);

    // Flush with four fetches outstanding plus a fresh redirected fetch.
    mem_ack_en = 1'b0;
    fetch_req_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_req_addr = 32'h8000_0010 + 32'(4 * i);
      @(negedge clk);
      check("t3_fill_rdy", fetch_req_rdy, 1);
      tick();
    end
    fetch_ack_cnt = 0;
    fetch_req_addr = 32'h8000_0100; fetch_flush = 1'b1;
    fetch_ack_rdy = 1'b0; mem_ack_en = 1'b1;
    @(negedge clk);
    check("t3_flush_req_rdy", fetch_req_rdy, 1);
    check("t3_flush_ack_vld", fetch_ack_vld, 0);
    check("t3_flush_mem_ack_rdy", mem_ack_rdy, 1);
    tick();
    fetch_flush = 1'b0; fetch_req_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_drop_ack_vld", fetch_ack_vld, 0);
      check("t3_drop_mem_ack_rdy", mem_ack_rdy, 1);
      tick();
    end
    @(negedge clk);
    check("t3_new_ack_vld", fetch_ack_vld, 1);
    check("t3_new_mem_ack_rdy", mem_ack_rdy, 0);
    check("t3_new_ack_data", fetch_ack_data, 32'hdead_beef);
    tick();
    fetch_ack_rdy = 1'b1;
    drain("t3");
    check("t3_fetch_acks", fetch_ack_cnt, 1);

    // Debug then fetch; stalled debug response blocks the fetch response.
    mem_ack_en = 1'b0; fetch_ack_cnt = 0; dbg_ack_cnt = 0;
    dbg_req_vld = 1'b1; dbg_req_addr = 32'h2000_0100;
    @(negedge clk);
    check("t4_dbg_rdy", dbg_req_rdy, 1);
    tick();
    dbg_req_vld = 1'b0; fetch_req_vld = 1'b1; fetch_req_addr = 32'h8000_0200;
    @(negedge clk);
    check("t4_fetch_rdy", fetch_req_rdy, 1);
    tick();
    fetch_req_vld = 1'b0; dbg_ack_rdy = 1'b0; mem_ack_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_dbg_vld", dbg_ack_vld, 1);
      check("t4_stall_mem_ack_rdy", mem_ack_rdy, 0);
      check("t4_stall_fetch_vld", fetch_ack_vld, 0);
      tick();
    end
    dbg_ack_rdy = 1'b1;
    @(negedge clk);
    check("t4_rel_dbg_vld", dbg_ack_vld, 1);
    check("t4_rel_mem_ack_rdy", mem_ack_rdy, 1);
    tick();
    @(negedge clk);
    check("t4_next_fetch_vld", fetch_ack_vld, 1);
    tick();
    drain("t4");
    check("t4_fetch_acks", fetch_ack_cnt, 1);
    check("t4_dbg_acks", dbg_ack_cnt, 1);

    // Memory stall: last grant was fetch, so debug holds the grant.
    mem_ack_en = 1'b0; mem_req_rdy = 1'b0;
    fetch_req_vld = 1'b1; fetch_req_addr = 32'h8000_0300;
    dbg_req_vld = 1'b1;   dbg_req_addr = 32'h2000_0300;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5_stall_vld", mem_req_vld, 1);
      check("t5_stall_addr", mem_req_addr, 32'h2000_0300);
      check("t5_stall_f_rdy", fetch_req_rdy, 0);
      check("t5_stall_d_rdy", dbg_req_rdy, 0);
      tick();
    end
    mem_req_rdy = 1'b1;
    @(negedge clk);
    check("t5_go_d_rdy", dbg_req_rdy, 1);
    tick();
    @(negedge clk);
    check("t5_next_f_rdy", fetch_req_rdy, 1);
    check("t5_next_addr", mem_req_addr, 32'h8000_0300);
    tick();
    fetch_req_vld = 1'b0; dbg_req_vld = 1'b0;
    drain("t5");

    // Reset with three requests outstanding.
    mem_ack_en = 1'b0; fetch_req_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_req_addr = 32'h8000_0400 + 32'(4 * i);
      @(negedge clk);
      check("t6_fill_rdy", fetch_req_rdy, 1);
      tick();
    end
    rst = 1'b1; dbg_req_vld = 1'b1; mem_ack_en = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    tick();
    rst = 1'b0; mem_ack_en = 1'b0;
    fa = 32'h8000_0500; da = 32'h2000_0500;
    for (int i = 0; i < 5; i++) begin
      fetch_req_addr = fa; dbg_req_addr = da;
      @(negedge clk);
      check("t6_grant_f", fetch_req_rdy, (i < 4) && (i % 2 == 0));
      check("t6_grant_d", dbg_req_rdy, (i < 4) && (i % 2 == 1));
      tick();
      if (i % 2 == 0) fa += 4; else da += 4;
    end
    fetch_req_vld = 1'b0; dbg_req_vld = 1'b0;
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
